// File: rtl/ov7725_cap_pkg.sv
// Shared types and constants for the OV7725 capture stage: FSM state
// encoding, default frame geometry and RGB565 field layout.
package ov7725_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  localparam int H_PIXEL_DEF  = 640;
  localparam int V_PIXEL_DEF  = 480;
  localparam int PIC_WAIT_DEF = 10;

  // RGB565 field positions within the 16-bit pixel
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // The sensor sends R[4:0]G[5:3] first, then G[2:0]B[4:0]; this places
  // the two bytes into their RGB565 fields.
  function automatic logic [15:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] px;
    px = '0;
    px[R_MSB:R_LSB] = hi[7:3];
    px[G_MSB:G_LSB] = {hi[2:0], lo[7:5]};
    px[B_MSB:B_LSB] = lo[4:0];
    return px;
  endfunction

endpackage

// File: rtl/ov7725_sync_edge.sv
// Input register stage for the camera bus. Registers href/vsync/data once,
// keeps a second stage of href and vsync, and derives the vsync rising edge
// and href falling edge used by the capture logic.
module ov7725_sync_edge (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_href,
  input  logic       i_vsync,
  input  logic [7:0] i_data,
  output logic       o_href_d,
  output logic [7:0] o_data_d,
  output logic       o_vs_rise,
  output logic       o_href_fall
);

  logic       r_href_d;
  logic       r_href_dd;
  logic       r_vsync_d;
  logic       r_vsync_dd;
  logic [7:0] r_data_d;

  // pipeline the camera pins; second stage only for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_href_d   <= 1'b0;
      r_href_dd  <= 1'b0;
      r_vsync_d  <= 1'b0;
      r_vsync_dd <= 1'b0;
      r_data_d   <= 8'h00;
    end else begin
      r_href_d   <= i_href;
      r_href_dd  <= r_href_d;
      r_vsync_d  <= i_vsync;
      r_vsync_dd <= r_vsync_d;
      r_data_d   <= i_data;
    end
  end

  assign o_href_d    = r_href_d;
  assign o_data_d    = r_data_d;
  assign o_vs_rise   = r_vsync_d & ~r_vsync_dd;
  // previous stage high, current stage low: last byte of the line has passed
  assign o_href_fall = r_href_dd & ~r_href_d;

endmodule

// File: rtl/ov7725_pixel_capture.sv
// OV7725 parallel-port capture: discards the first PIC_WAIT frames after
// init, packs byte pairs into RGB565 pixels with a write strobe per pixel,
// marks frame boundaries and flags malformed lines.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for sys_init_done; skip counter held at zero
// SKIP    | counting vsync rising edges while the sensor settles
// CAPTURE | pixels written; each vsync rise starts a new frame
module ov7725_pixel_capture
  import ov7725_cap_pkg::*;
#(
  parameter int H_PIXEL  = H_PIXEL_DEF,
  parameter int V_PIXEL  = V_PIXEL_DEF,
  parameter int PIC_WAIT = PIC_WAIT_DEF
) (
  input  logic        ov7725_pclk,
  input  logic        sys_rst_n,
  input  logic        sys_init_done,
  input  logic        ov7725_href,
  input  logic        ov7725_vsync,
  input  logic [7:0]  ov7725_data,
  output logic        ov7725_wr_en,
  output logic [15:0] ov7725_data_out,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic [7:0]  frame_cnt
);

  logic       w_href_d;
  logic [7:0] w_data_d;
  logic       w_vs_rise;
  logic       w_href_fall;
  logic       w_capture;
  logic       w_wr_ok;

  cap_state_t  r_state;
  logic [7:0]  r_skip_cnt;
  logic        r_frame_start;
  logic [7:0]  r_frame_cnt;

  logic        r_phase;
  logic [7:0]  r_hi_byte;
  logic [10:0] r_pix_cnt;
  logic [9:0]  r_line_cnt;
  logic        r_wr_en;
  logic [15:0] r_data_out;
  logic        r_frame_done;
  logic        r_line_err;

  ov7725_sync_edge u_sync_edge (
    .i_clk       (ov7725_pclk),
    .i_rst_n     (sys_rst_n),
    .i_href      (ov7725_href),
    .i_vsync     (ov7725_vsync),
    .i_data      (ov7725_data),
    .o_href_d    (w_href_d),
    .o_data_d    (w_data_d),
    .o_vs_rise   (w_vs_rise),
    .o_href_fall (w_href_fall)
  );

  // dropping init stops strobes at the very next edge, ahead of the IDLE transition
  assign w_capture = (r_state == ST_CAPTURE) && sys_init_done;
  assign w_wr_ok   = w_capture
                     && (r_pix_cnt < 11'(H_PIXEL))
                     && (r_line_cnt < 10'(V_PIXEL));

  // frame sequencing: settle-skip after init, then frame boundaries while capturing
  always_ff @(posedge ov7725_pclk) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_skip_cnt    <= 8'h00;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'h00;
    end else begin
      r_frame_start <= 1'b0;
      if (!sys_init_done) begin
        r_state    <= ST_IDLE;
        r_skip_cnt <= 8'h00;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_skip_cnt <= 8'h00;
            r_state    <= ST_SKIP;
          end
          ST_SKIP: begin
            if (w_vs_rise) begin
              r_skip_cnt <= r_skip_cnt + 8'd1;
              if (r_skip_cnt == 8'(PIC_WAIT - 1)) begin
                r_state       <= ST_CAPTURE;
                r_frame_start <= 1'b1;
              end
            end
          end
          ST_CAPTURE: begin
            if (w_vs_rise) begin
              r_frame_start <= 1'b1;
              r_frame_cnt   <= r_frame_cnt + 8'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // byte packing, pixel/line counting, strobes and line geometry checks
  always_ff @(posedge ov7725_pclk) begin
    if (!sys_rst_n) begin
      r_phase      <= 1'b0;
      r_hi_byte    <= 8'h00;
      r_pix_cnt    <= 11'd0;
      r_line_cnt   <= 10'd0;
      r_wr_en      <= 1'b0;
      r_data_out   <= 16'h0000;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_vs_rise) begin
        // vsync wins over an unfinished line: partial byte and counters dropped
        r_phase    <= 1'b0;
        r_pix_cnt  <= 11'd0;
        r_line_cnt <= 10'd0;
      end else if (w_href_d) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_hi_byte <= w_data_d;
        end else begin
          if (w_wr_ok) begin
            r_wr_en    <= 1'b1;
            r_data_out <= rgb565_pack(r_hi_byte, w_data_d);
          end
          // saturate so a runaway href can never wrap back into the valid window
          if (r_pix_cnt != 11'h7FF) begin
            r_pix_cnt <= r_pix_cnt + 11'd1;
          end
        end
      end else begin
        r_phase <= 1'b0;
        if (w_href_fall) begin
          r_pix_cnt <= 11'd0;
          if (r_line_cnt < 10'(V_PIXEL)) begin
            r_line_cnt <= r_line_cnt + 10'd1;
          end
          if (w_capture) begin
            // r_phase still holds the phase of the last byte here: 1 means an odd byte
            if ((r_pix_cnt != 11'(H_PIXEL)) || r_phase) begin
              r_line_err <= 1'b1;
            end
            if (r_line_cnt == 10'(V_PIXEL - 1)) begin
              r_frame_done <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign ov7725_wr_en    = r_wr_en;
  assign ov7725_data_out = r_data_out;
  assign frame_start     = r_frame_start;
  assign frame_done      = r_frame_done;
  assign line_err        = r_line_err;
  assign frame_cnt       = r_frame_cnt;

endmodule

// File: tb/tb_ov7725_pixel_capture.sv
// Self-checking bench for ov7725_pixel_capture with a reduced frame geometry.
module tb_ov7725_pixel_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int PW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic        href = 1'b0;
  logic        vsync = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        wr_en;
  logic [15:0] dout;
  logic        fs;
  logic        fd;
  logic        lerr;
  logic [7:0]  fcnt;

  int checks = 0;
  int errors = 0;

  ov7725_pixel_capture #(.H_PIXEL(H), .V_PIXEL(V), .PIC_WAIT(PW)) dut (
    .ov7725_pclk     (clk),
    .sys_rst_n       (rst_n),
    .sys_init_done   (init),
    .ov7725_href     (href),
    .ov7725_vsync    (vsync),
    .ov7725_data     (data),
    .ov7725_wr_en    (wr_en),
    .ov7725_data_out (dout),
    .frame_start     (fs),
    .frame_done      (fd),
    .line_err        (lerr),
    .frame_cnt       (fcnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed events
  logic [15:0] got_q[$];
  int          got_c[$];
  int fs_cnt = 0, fd_cnt = 0, overlap = 0, last_fs_cyc = -100;
  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back(dout);
      got_c.push_back(cyc);
    end
    if (fs) begin
      fs_cnt      <= fs_cnt + 1;
      last_fs_cyc <= cyc;
    end
    if (fd) fd_cnt <= fd_cnt + 1;
    if (fd && wr_en) overlap <= overlap + 1;
  end

  // reference model: 0 idle, 1 skipping, 2 capturing
  int m_mode = 0, m_skip = 0, m_line = 0, m_fd = 0, m_fcnt = 0;
  bit m_err = 0;
  logic [15:0] exp_q[$];
  int b1_cyc = 0, drop_cyc = 0;

  task automatic step(input logic h, input logic v, input logic [7:0] d);
    @(posedge clk); #1;
    href = h; vsync = v; data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_queues();
    got_q.delete(); got_c.delete(); exp_q.delete();
  endtask

  task automatic send_line(input int nbytes, input bit f81f, input int drop_at);
    logic [7:0] b, hi;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom_range(0, 255));
      if (f81f && i == 0) b = 8'hF8;
      if (f81f && i == 1) b = 8'h1F;
      @(posedge clk); #1;
      href = 1'b1; vsync = 1'b0; data = b;
      if (f81f && i == 1) b1_cyc = cyc;
      if (i == drop_at) begin init = 1'b0; drop_cyc = cyc; end
      if (i % 2 == 0) hi = b;
      else if (m_mode == 2 && (i / 2) < H && m_line < V && (drop_at < 0 || i < drop_at - 1))
        exp_q.push_back({hi, b});
    end
    if (drop_at >= 0) m_mode = 0;
    idle(4);
    if (m_mode == 2) begin
      if (nbytes != 2 * H) m_err = 1;
      if (m_line == V - 1) m_fd++;
    end
    m_line++;
  endtask

  task automatic send_vsync(output bit obs_fire, output bit exp_fire, output int lat);
    int vs_cyc, fs0;
    fs0 = fs_cnt;
    step(1'b0, 1'b1, 8'h00);
    vs_cyc = cyc;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    idle(3);
    exp_fire = 0;
    if (m_mode == 1) begin
      m_skip++;
      if (m_skip == PW) begin m_mode = 2; exp_fire = 1; end
    end else if (m_mode == 2) begin
      exp_fire = 1;
      m_fcnt = (m_fcnt + 1) % 256;
    end
    m_line = 0;
    obs_fire = (fs_cnt != fs0);
    lat = last_fs_cyc - vs_cyc;
  endtask

  task automatic send_frame(input int bad_line, input int bad_bytes, input bit f81f,
                            output bit obs_fire, output bit exp_fire, output int lat);
    for (int l = 0; l < V; l++)
      send_line((l == bad_line) ? bad_bytes : 2 * H, f81f && (l == 0), -1);
    send_vsync(obs_fire, exp_fire, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_data_out: got %h want 0000", dout); end
    checks++; if (fs !== 1'b0 || fd !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fs=%b fd=%b want 0 0", fs, fd); end
    checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL reset_line_err: got %b want 0", lerr); end
    checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", fcnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_mode = 0;
    idle(2);
  endtask

  task automatic test_skip_capture();
    bit o, e; int lat;
    clear_queues();
    init = 1'b1; m_mode = 1; m_skip = 0;
    idle(3);
    for (int f = 0; f < PW + 2; f++) begin
      send_frame(-1, 0, 1'b0, o, e, lat);
      checks++;
      if (o !== e) begin errors++; $display("FAIL skip_fs_frame%0d: got fired=%b want %b", f, o, e); end
      if (e) begin
        checks++;
        if (lat != 2) begin errors++; $display("FAIL skip_fs_latency: got %0d want 2", lat); end
      end
      if (f == PW - 1) begin
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL skip_no_strobes: got %0d want 0", got_q.size()); end
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL cap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL cap_pixel[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt != m_fd) begin errors++; $display("FAIL cap_frame_done: got %0d want %0d", fd_cnt, m_fd); end
    checks++; if (fcnt !== 8'(m_fcnt)) begin errors++; $display("FAIL cap_frame_cnt: got %0d want %0d", fcnt, m_fcnt); end
    checks++; if (lerr !== m_err) begin errors++; $display("FAIL cap_line_err: got %b want %b", lerr, m_err); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL cap_fd_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_pixel_latency();
    bit o, e; int lat;
    clear_queues();
    send_frame(-1, 0, 1'b1, o, e, lat);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL lat_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'hF81F) begin errors++; $display("FAIL lat_value: got %h want f81f", got_q[0]); end
      checks++; if (got_c[0] - b1_cyc != 2) begin errors++; $display("FAIL lat_cycles: got %0d want 2", got_c[0] - b1_cyc); end
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lat_pixel[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (o !== e || lat != 2) begin errors++; $display("FAIL lat_fs: got fired=%b lat=%0d want %b 2", o, lat, e); end
    checks++; if (fcnt !== 8'(m_fcnt)) begin errors++; $display("FAIL lat_frame_cnt: got %0d want %0d", fcnt, m_fcnt); end
  endtask

  task automatic test_short_line();
    bit o, e; int lat;
    clear_queues();
    send_frame(1, 2 * H - 2, 1'b0, o, e, lat);
    checks++; if (lerr !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL short_line_err: got %b want 1", lerr); end
    send_frame(-1, 0, 1'b0, o, e, lat);
    checks++; if (lerr !== 1'b1) begin errors++; $display("FAIL short_err_held: got %b want 1", lerr); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL short_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_pixel[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt != m_fd) begin errors++; $display("FAIL short_frame_done: got %0d want %0d", fd_cnt, m_fd); end
    checks++; if (fcnt !== 8'(m_fcnt)) begin errors++; $display("FAIL short_frame_cnt: got %0d want %0d", fcnt, m_fcnt); end
  endtask

  task automatic test_long_line();
    bit o, e; int lat;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    m_mode = 1; m_skip = 0; m_err = 0; m_fcnt = 0; m_line = 0;
    idle(3);
    clear_queues();
    checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL long_err_cleared: got %b want 0", lerr); end
    for (int f = 0; f < PW; f++) send_frame(-1, 0, 1'b0, o, e, lat);
    checks++; if (o !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL long_entry_fs: got %b want 1", o); end
    send_frame(2, 2 * H + 3, 1'b0, o, e, lat);
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != V * H) begin errors++; $display("FAIL long_count: got %0d want %0d", got_q.size(), V * H); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL long_pixel[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (lerr !== 1'b1) begin errors++; $display("FAIL long_line_err: got %b want 1", lerr); end
    checks++; if (fcnt !== 8'(m_fcnt)) begin errors++; $display("FAIL long_frame_cnt: got %0d want %0d", fcnt, m_fcnt); end
  endtask

  task automatic test_init_drop();
    bit o, e; int lat, late;
    clear_queues();
    send_line(2 * H, 1'b0, -1);
    send_line(2 * H, 1'b0, 6);
    for (int l = 2; l < V; l++) send_line(2 * H, 1'b0, -1);
    send_vsync(o, e, lat);
    late = 0;
    foreach (got_c[i]) if (got_c[i] > drop_cyc) late++;
    checks++; if (late != 0) begin errors++; $display("FAIL drop_late_strobes: got %0d want 0", late); end
    checks++; if (got_q.size() != H + 2) begin errors++; $display("FAIL drop_count: got %0d want %0d", got_q.size(), H + 2); end
    checks++; if (o !== e) begin errors++; $display("FAIL drop_fs: got %b want %b", o, e); end
    init = 1'b1; m_mode = 1; m_skip = 0;
    idle(3);
    for (int f = 0; f < PW; f++) begin
      send_frame(-1, 0, 1'b0, o, e, lat);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reskip_fs_frame%0d: got %b want %b", f, o, e); end
    end
    checks++; if (got_q.size() != H + 2) begin errors++; $display("FAIL reskip_no_strobes: got %0d want %0d", got_q.size(), H + 2); end
    send_frame(-1, 0, 1'b0, o, e, lat);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_total: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_pixel[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fcnt !== 8'(m_fcnt)) begin errors++; $display("FAIL drop_frame_cnt: got %0d want %0d", fcnt, m_fcnt); end
  endtask

  task automatic test_reset_midframe();
    bit o, e; int lat;
    checks++; if (fcnt === 8'd0) begin errors++; $display("FAIL midrst_precond: got frame_cnt %0d want nonzero", fcnt); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    @(posedge clk); #1;
    rst_n = 1'b0; data = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    checks++; if (wr_en !== 1'b0 || dout !== 16'h0000) begin errors++; $display("FAIL midrst_strobe: got wr=%b data=%h want 0 0000", wr_en, dout); end
    checks++; if (fs !== 1'b0 || fd !== 1'b0 || lerr !== 1'b0) begin errors++; $display("FAIL midrst_flags: got fs=%b fd=%b err=%b want 0", fs, fd, lerr); end
    checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d want 0", fcnt); end
    @(posedge clk); #1;
    rst_n = 1'b1; href = 1'b0;
    m_mode = 1; m_skip = 0; m_err = 0; m_fcnt = 0; m_line = 0;
    idle(3);
    clear_queues();
    send_frame(-1, 0, 1'b0, o, e, lat);
    checks++; if (got_q.size() != 0 || o !== 1'b0) begin errors++; $display("FAIL midrst_reskip: got %0d strobes fired=%b want 0 0", got_q.size(), o); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL final_fd_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_skip_capture();
    test_pixel_latency();
    test_short_line();
    test_long_line();
    test_init_drop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
